// File: rtl/dly_tap_seq_ctrl.sv
// Delay-line tap sequencer: steps one selected delay line toward a requested tap value,
// reading the selected line's tap back through the tap-value mux between adjust pulses.
module dly_tap_seq_ctrl #(
  parameter int NUM_LINES  = 20,
  parameter int ADDR_W     = 5,
  parameter int TAP_W      = 6,
  parameter int SETTLE_CYC = 3,
  parameter int MAX_STEPS  = 63
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 REQ_VALID,
  output logic                 REQ_READY,
  input  logic [ADDR_W-1:0]    REQ_ADDR,
  input  logic [TAP_W-1:0]     REQ_TARGET,
  output logic [ADDR_W-1:0]    DLY_ADDR,
  input  logic [TAP_W-1:0]     DLY_TAP_VALUE,
  output logic [NUM_LINES-1:0] DLY_ADJ,
  output logic                 DLY_INCDEC,
  output logic                 BUSY,
  output logic                 DONE,
  output logic                 ERR
);

  localparam int STEP_W = $clog2(MAX_STEPS + 1);
  localparam int SET_W  = $clog2(SETTLE_CYC + 1);
  localparam logic [SET_W-1:0]  SETTLE_LOAD = SET_W'(SETTLE_CYC - 1);
  localparam logic [STEP_W-1:0] STEP_LIMIT  = STEP_W'(MAX_STEPS);
  localparam logic [ADDR_W:0]   LINE_LIMIT  = (ADDR_W + 1)'(NUM_LINES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_COMPARE,
    S_STEP,
    S_FINISH
  } state_t;

  state_t                r_state;
  logic                  r_ready;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_err;
  logic                  r_incdec;
  logic [ADDR_W-1:0]     r_addr;
  logic [NUM_LINES-1:0]  r_adj;
  logic [TAP_W-1:0]      r_target;
  logic [STEP_W-1:0]     r_steps;
  logic [SET_W-1:0]      r_settle;

  logic                  w_bad_addr;
  logic [NUM_LINES-1:0]  w_onehot;

  assign w_bad_addr = {1'b0, REQ_ADDR} >= LINE_LIMIT;
  assign w_onehot   = {{(NUM_LINES-1){1'b0}}, 1'b1} << r_addr;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state  <= S_IDLE;
      r_ready  <= 1'b1;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_incdec <= 1'b0;
      r_addr   <= '0;
      r_adj    <= '0;
      r_target <= '0;
      r_steps  <= '0;
      r_settle <= '0;
    end else begin
      // Adjust pulse is set on entry to STEP and self-clears after one cycle.
      r_adj <= '0;
      case (r_state)
        S_IDLE: begin
          if (REQ_VALID) begin
            r_target <= REQ_TARGET;
            r_steps  <= '0;
            r_ready  <= 1'b0;
            r_busy   <= 1'b1;
            if (w_bad_addr) begin
              r_done  <= 1'b1;
              r_err   <= 1'b1;
              r_state <= S_FINISH;
            end else begin
              r_addr   <= REQ_ADDR;
              r_settle <= SETTLE_LOAD;
              r_state  <= S_SETTLE;
            end
          end
        end
        S_SETTLE: begin
          if (r_settle == '0) r_state <= S_COMPARE;
          else                r_settle <= r_settle - 1'b1;
        end
        S_COMPARE: begin
          if (DLY_TAP_VALUE == r_target) begin
            r_done  <= 1'b1;
            r_err   <= 1'b0;
            r_state <= S_FINISH;
          end else if (r_steps == STEP_LIMIT) begin
            r_done  <= 1'b1;
            r_err   <= 1'b1;
            r_state <= S_FINISH;
          end else begin
            r_adj    <= w_onehot;
            r_incdec <= r_target > DLY_TAP_VALUE;
            r_state  <= S_STEP;
          end
        end
        S_STEP: begin
          r_steps  <= r_steps + 1'b1;
          r_settle <= SETTLE_LOAD;
          r_state  <= S_SETTLE;
        end
        S_FINISH: begin
          r_done  <= 1'b0;
          r_err   <= 1'b0;
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign REQ_READY  = r_ready;
  assign BUSY       = r_busy;
  assign DONE       = r_done;
  assign ERR        = r_err;
  assign DLY_INCDEC = r_incdec;
  assign DLY_ADDR   = r_addr;
  assign DLY_ADJ    = r_adj;

endmodule

// File: tb/tb_dly_tap_seq_ctrl.sv
// Bench for dly_tap_seq_ctrl: behavioural delay-line model, directed table, random requests,
// plus reset-during-step and back-to-back sequences.
module tb_dly_tap_seq_ctrl;

  localparam int NL = 20;
  localparam int S  = 3;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          REQ_VALID = 1'b0;
  logic          REQ_READY;
  logic [4:0]    REQ_ADDR = '0;
  logic [5:0]    REQ_TARGET = '0;
  logic [4:0]    DLY_ADDR;
  logic [5:0]    DLY_TAP_VALUE;
  logic [NL-1:0] DLY_ADJ;
  logic          DLY_INCDEC;
  logic          BUSY;
  logic          DONE;
  logic          ERR;

  dly_tap_seq_ctrl #(
    .NUM_LINES(NL), .ADDR_W(5), .TAP_W(6), .SETTLE_CYC(S), .MAX_STEPS(63)
  ) dut (
    .CLK(CLK), .RST(RST), .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
    .REQ_ADDR(REQ_ADDR), .REQ_TARGET(REQ_TARGET), .DLY_ADDR(DLY_ADDR),
    .DLY_TAP_VALUE(DLY_TAP_VALUE), .DLY_ADJ(DLY_ADJ), .DLY_INCDEC(DLY_INCDEC),
    .BUSY(BUSY), .DONE(DONE), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  // Delay-line model: saturating 0..63 taps, optional stuck line ignoring adjust pulses.
  logic [5:0] taps  [NL];
  logic       stuck [NL];
  logic       set_en = 1'b0;
  int         set_line = 0;
  logic [5:0] set_val = '0;
  logic       set_stuck = 1'b0;

  always @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < NL; i++) begin
        taps[i]  <= '0;
        stuck[i] <= 1'b0;
      end
    end else if (set_en) begin
      taps[set_line]  <= set_val;
      stuck[set_line] <= set_stuck;
    end else begin
      for (int i = 0; i < NL; i++) begin
        if (DLY_ADJ[i] && !stuck[i]) begin
          if (DLY_INCDEC && taps[i] != 6'd63) taps[i] <= taps[i] + 6'd1;
          else if (!DLY_INCDEC && taps[i] != 6'd0) taps[i] <= taps[i] - 6'd1;
        end
      end
    end
  end

  assign DLY_TAP_VALUE = (int'(DLY_ADDR) < NL) ? taps[DLY_ADDR] : 6'd0;

  // Pulse monitor: cumulative counts, the request task looks at deltas.
  int   mon_pulses = 0, mon_badbit = 0, mon_baddir = 0;
  int   cur_addr = 0;
  logic cur_dir = 1'b0;

  always @(negedge CLK) begin
    if (!RST && DLY_ADJ != '0) begin
      mon_pulses++;
      if (cur_addr >= NL || DLY_ADJ != (NL'(1) << cur_addr)) mon_badbit++;
      if (DLY_INCDEC != cur_dir) mon_baddir++;
    end
  end

  int total = 0, bad = 0;
  int last_addr = 0;

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic set_tap(input int line, input int val, input logic stk);
    @(negedge CLK);
    set_en = 1'b1; set_line = line; set_val = 6'(val); set_stuck = stk;
    @(negedge CLK);
    set_en = 1'b0;
  endtask

  task automatic run_req(input int addr, input int target, input int exp_lat, input int exp_err,
                         input int exp_pulses, input logic exp_dir);
    int p0, b0, d0, n, lat, err_seen;
    @(negedge CLK);
    n = 0;
    while (!REQ_READY && n < 50) begin @(negedge CLK); n++; end
    check("ready_before_req", int'(REQ_READY), 1);
    REQ_VALID = 1'b1; REQ_ADDR = 5'(addr); REQ_TARGET = 6'(target);
    cur_addr = addr; cur_dir = exp_dir;
    p0 = mon_pulses; b0 = mon_badbit; d0 = mon_baddir;
    @(posedge CLK); #1;
    REQ_VALID = 1'b0;
    n = 1; lat = -1; err_seen = -1;
    while (n <= 400) begin
      if (DONE) begin lat = n; err_seen = int'(ERR); break; end
      @(posedge CLK); #1;
      n++;
    end
    check("done_latency", lat, exp_lat);
    check("err", err_seen, exp_err);
    @(negedge CLK);
    check("pulse_count", mon_pulses - p0, exp_pulses);
    check("pulse_wrong_line", mon_badbit - b0, 0);
    check("pulse_wrong_dir", mon_baddir - d0, 0);
    if (addr < NL) last_addr = addr;
    check("dly_addr_after", int'(DLY_ADDR), last_addr);
  endtask

  typedef struct {
    int   addr, target, init, stk, lat, err, pulses;
    logic dir;
  } vec_t;

  vec_t vecs [6];

  initial begin
    vecs[0] = '{addr: 4,  target: 10, init: 10, stk: 0, lat: 5,   err: 0, pulses: 0,  dir: 1'b0};
    vecs[1] = '{addr: 7,  target: 22, init: 20, stk: 0, lat: 15,  err: 0, pulses: 2,  dir: 1'b1};
    vecs[2] = '{addr: 19, target: 2,  init: 5,  stk: 0, lat: 20,  err: 0, pulses: 3,  dir: 1'b0};
    vecs[3] = '{addr: 25, target: 0,  init: 0,  stk: 0, lat: 1,   err: 1, pulses: 0,  dir: 1'b0};
    vecs[4] = '{addr: 0,  target: 0,  init: 63, stk: 1, lat: 320, err: 1, pulses: 63, dir: 1'b0};
    vecs[5] = '{addr: 12, target: 63, init: 0,  stk: 0, lat: 320, err: 0, pulses: 63, dir: 1'b1};

    repeat (3) @(posedge CLK);
    #1 RST = 1'b0;
    check("rst_flags", int'({REQ_READY, BUSY, DONE, ERR, DLY_INCDEC}), 'b10000);
    check("rst_addr", int'(DLY_ADDR), 0);
    check("rst_adj", int'(DLY_ADJ), 0);

    for (int i = 0; i < 6; i++) begin
      if (vecs[i].addr < NL) set_tap(vecs[i].addr, vecs[i].init, 1'(vecs[i].stk));
      run_req(vecs[i].addr, vecs[i].target, vecs[i].lat, vecs[i].err, vecs[i].pulses, vecs[i].dir);
    end

    // Random requests against an arithmetic reference: k = |target - tap| pulses.
    for (int i = 0; i < 25; i++) begin
      int a, t, ini, k;
      a   = $urandom_range(0, 23);
      t   = $urandom_range(0, 63);
      ini = $urandom_range(0, 63);
      if (a < NL) begin
        set_tap(a, ini, 1'b0);
        k = (t > ini) ? t - ini : ini - t;
        run_req(a, t, (S + 2) * (k + 1), 0, k, t > ini);
      end else begin
        run_req(a, t, 1, 1, 0, 1'b0);
      end
    end

    // Reset while an adjust pulse is in flight.
    begin
      int n, dones;
      set_tap(7, 20, 1'b0);
      @(negedge CLK);
      REQ_VALID = 1'b1; REQ_ADDR = 5'd7; REQ_TARGET = 6'd22; cur_addr = 7; cur_dir = 1'b1;
      @(posedge CLK); #1;
      REQ_VALID = 1'b0;
      n = 0;
      while (DLY_ADJ == '0 && n < 30) begin @(posedge CLK); #1; n++; end
      check("step_reached", int'(DLY_ADJ != '0), 1);
      RST = 1'b1;
      @(posedge CLK); #1;
      RST = 1'b0;
      check("midrst_flags", int'({REQ_READY, BUSY, DONE, ERR, DLY_INCDEC}), 'b10000);
      check("midrst_addr", int'(DLY_ADDR), 0);
      check("midrst_adj", int'(DLY_ADJ), 0);
      last_addr = 0;
      dones = 0;
      for (int c = 0; c < 8; c++) begin
        @(posedge CLK); #1;
        if (DONE) dones++;
      end
      check("midrst_no_done", dones, 0);
      set_tap(3, 3, 1'b0);
      run_req(3, 3, 5, 0, 0, 1'b0);
    end

    // Back-to-back: VALID held, second request accepted right after FINISH.
    begin
      int n, d1, d2;
      set_tap(4, 10, 1'b0);
      @(negedge CLK);
      REQ_VALID = 1'b1; REQ_ADDR = 5'd4; REQ_TARGET = 6'd10; cur_addr = 4;
      @(posedge CLK); #1;
      d1 = -1; d2 = -1;
      for (n = 1; n <= 11; n++) begin
        if (DONE) begin
          if (d1 < 0) d1 = n;
          else d2 = n;
        end
        if (n < 11) begin @(posedge CLK); #1; end
      end
      REQ_VALID = 1'b0;
      check("b2b_first_done", d1, 5);
      check("b2b_second_done", d2, 11);
      repeat (3) @(posedge CLK);
      #1 check("b2b_idle_ready", int'({REQ_READY, BUSY}), 'b10);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
